// File: rtl/video_pkg.sv
// Shared types and constants for the video write buffer: FSM states and FIFO entry layout.
package video_pkg;

    localparam logic [31:0] VRAM_BASE  = 32'h0000_8000;
    localparam int unsigned VID_ADDR_W = 12;

    typedef enum logic [1:0] {
        StRun,
        StDrainPre,
        StClear
    } state_t;

    typedef struct packed {
        logic [VID_ADDR_W-1:0] idx;
        logic [31:0]           data;
    } entry_t;

endpackage

// File: rtl/video_fifo.sv
// Synchronous FIFO of framebuffer writes with a port to rewrite the newest entry in place.
module video_fifo
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    input  logic             overwrite,
    input  logic [31:0]      overwrite_data,
    output entry_t           head,
    output entry_t           newest,
    output logic [LVL_W-1:0] level
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] last_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign last_ptr = wptr_q - PTR_W'(1);
    assign head     = mem[rptr_q];
    assign newest   = mem[last_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!push && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= push_data;
        end else if (overwrite) begin
            mem[last_ptr].data <= overwrite_data;
        end
    end

endmodule

// File: rtl/video_write_buffer.sv
// Buffers core VRAM stores (address filter, write-combining) and drains them to the framebuffer,
// with a full-screen clear ordered after all stores buffered before the clear request.
module video_write_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] VRAM_BASE = video_pkg::VRAM_BASE,
    parameter int unsigned FB_WORDS  = 4096,
    parameter int unsigned ADDR_W    = 12,
    localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       video_addr,
    input  logic [31:0]       video_data,
    input  logic              video_we,
    input  logic              clear_req,
    input  logic [31:0]       clear_data,
    output logic              fb_valid,
    input  logic              fb_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy,
    output logic              clear_done,
    output logic [15:0]       overflow_count,
    output logic [15:0]       oob_count
);

    import video_pkg::*;

    localparam logic [31:0]       FB_BYTES = 32'(FB_WORDS * 4);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FB_WORDS - 1);

    state_t            state_q;
    logic [LVL_W-1:0]  pre_cnt_q;
    logic [LVL_W-1:0]  pre_next;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [31:0]       clr_data_q;

    logic [31:0]       offset;
    logic [ADDR_W-1:0] in_idx;
    logic              illegal;
    logic              legal;
    logic              fifo_valid;
    logic              drain_st;
    logic              pop;
    logic              combine;
    logic              push;
    logic              ovf_inc;
    logic              oob_inc;
    entry_t            push_entry;
    entry_t            head;
    entry_t            newest;

    assign offset     = video_addr - VRAM_BASE;
    assign illegal    = (video_addr < VRAM_BASE) || (video_addr[1:0] != 2'b00) ||
                        (offset >= FB_BYTES);
    assign legal      = video_we && !illegal;
    assign in_idx     = offset[ADDR_W+1:2];
    assign push_entry = '{idx: in_idx, data: video_data};

    assign fifo_valid = (fifo_level != '0);
    assign drain_st   = (state_q == StRun) || (state_q == StDrainPre);
    assign pop        = drain_st && fifo_valid && fb_ready;

    // A lone entry leaving this cycle can no longer absorb a merge.
    assign combine = legal && (state_q == StRun) && !clear_req && fifo_valid &&
                     (newest.idx == in_idx) && !((fifo_level == LVL_W'(1)) && pop);
    assign push    = legal && !combine && ((fifo_level < LVL_W'(DEPTH)) || pop);
    assign ovf_inc = legal && !combine && !push;
    assign oob_inc = video_we && illegal;

    assign pre_next = fifo_level - LVL_W'(pop);
    assign busy     = (state_q != StRun);

    video_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .push_data     (push_entry),
        .pop           (pop),
        .overwrite     (combine),
        .overwrite_data(video_data),
        .head          (head),
        .newest        (newest),
        .level         (fifo_level)
    );

    always_comb begin
        fb_valid = 1'b0;
        fb_addr  = '0;
        fb_data  = '0;
        if (state_q == StClear) begin
            fb_valid = 1'b1;
            fb_addr  = clr_idx_q;
            fb_data  = clr_data_q;
        end else if (fifo_valid) begin
            fb_valid = 1'b1;
            fb_addr  = head.idx;
            fb_data  = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pre_cnt_q  <= '0;
            clr_idx_q  <= '0;
            clr_data_q <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (clear_req) begin
                        clr_data_q <= clear_data;
                        clr_idx_q  <= '0;
                        pre_cnt_q  <= pre_next;
                        state_q    <= (pre_next == '0) ? StClear : StDrainPre;
                    end
                end
                StDrainPre: begin
                    if (pop) begin
                        pre_cnt_q <= pre_cnt_q - LVL_W'(1);
                        if (pre_cnt_q == LVL_W'(1)) begin
                            state_q <= StClear;
                        end
                    end
                end
                StClear: begin
                    if (fb_ready) begin
                        if (clr_idx_q == LAST_IDX) begin
                            state_q    <= StRun;
                            clear_done <= 1'b1;
                        end else begin
                            clr_idx_q <= clr_idx_q + ADDR_W'(1);
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_count <= '0;
            oob_count      <= '0;
        end else begin
            if (ovf_inc && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
            if (oob_inc && (oob_count != 16'hFFFF)) begin
                oob_count <= oob_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_write_buffer.sv
// Directed bench for video_write_buffer: queue-based reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_video_write_buffer;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned FB_WORDS = 4096;
    localparam int unsigned ADDR_W   = 12;
    localparam logic [31:0] BASE     = 32'h0000_8000;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       video_addr;
    logic [31:0]       video_data;
    logic              video_we;
    logic              clear_req;
    logic [31:0]       clear_data;
    logic              fb_valid;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [31:0]       fb_data;
    logic [3:0]        fifo_level;
    logic              busy;
    logic              clear_done;
    logic [15:0]       overflow_count;
    logic [15:0]       oob_count;

    always #5 clk = ~clk;

    video_write_buffer #(
        .DEPTH    (DEPTH),
        .VRAM_BASE(BASE),
        .FB_WORDS (FB_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .video_addr    (video_addr),
        .video_data    (video_data),
        .video_we      (video_we),
        .clear_req     (clear_req),
        .clear_data    (clear_data),
        .fb_valid      (fb_valid),
        .fb_ready      (fb_ready),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .clear_done    (clear_done),
        .overflow_count(overflow_count),
        .oob_count     (oob_count)
    );

    typedef struct packed {
        logic [11:0] idx;
        logic [31:0] data;
    } wr_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model: pending writes as a queue; mode 0 normal, 1 draining pre-clear
    // writes, 2 clearing the screen.
    wr_t         mq[$];
    int          m_mode = 0;
    int          m_pre  = 0;
    int          m_clr  = 0;
    int          m_ovf  = 0;
    int          m_oob  = 0;
    logic [31:0] m_cdata = '0;
    bit          m_done = 0;
    bit          checking = 0;

    bit          s_ok;
    bit          s_pop;
    bit          s_push;
    int          s_n;
    logic [11:0] s_idx;
    wr_t         s_new;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_mode = 0; m_pre = 0; m_clr = 0; m_ovf = 0; m_oob = 0;
            m_cdata = '0; m_done = 0;
            checking = 1;
        end else if (checking) begin
            s_n    = mq.size();
            s_pop  = (m_mode != 2) && (s_n > 0) && fb_ready;
            s_push = 0;
            s_ok   = (video_addr >= BASE) && (video_addr % 4 == 0) &&
                     ((video_addr - BASE) < FB_WORDS * 4);
            s_idx  = 12'((video_addr - BASE) / 4);
            m_done = 0;
            if (video_we) begin
                if (!s_ok) begin
                    if (m_oob < 65535) m_oob++;
                end else if (m_mode == 0 && !clear_req && s_n > 0 && mq[s_n-1].idx == s_idx &&
                             !(s_n == 1 && s_pop)) begin
                    mq[s_n-1].data = video_data;
                end else if (s_n < DEPTH || s_pop) begin
                    s_push = 1;
                    s_new.idx  = s_idx;
                    s_new.data = video_data;
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
            end
            if (s_pop) void'(mq.pop_front());
            if (s_push) mq.push_back(s_new);
            case (m_mode)
                0: if (clear_req) begin
                    m_cdata = clear_data;
                    m_clr   = 0;
                    m_pre   = s_n - (s_pop ? 1 : 0);
                    m_mode  = (m_pre == 0) ? 2 : 1;
                end
                1: if (s_pop) begin
                    m_pre--;
                    if (m_pre == 0) m_mode = 2;
                end
                default: if (fb_ready) begin
                    if (m_clr == FB_WORDS - 1) begin
                        m_mode = 0;
                        m_done = 1;
                    end else begin
                        m_clr++;
                    end
                end
            endcase
        end
    end

    wr_t wlog[$];
    bit  done_seen = 0;

    initial forever begin
        @(negedge clk);
        if (checking && !rst) begin
            check("fb_valid", 32'(fb_valid), 32'(m_mode == 2 || mq.size() > 0));
            if (m_mode == 2) begin
                check("fb_addr_clr", 32'(fb_addr), 32'(m_clr));
                check("fb_data_clr", fb_data, m_cdata);
            end else if (mq.size() > 0) begin
                check("fb_addr", 32'(fb_addr), 32'(mq[0].idx));
                check("fb_data", fb_data, mq[0].data);
            end
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("clear_done", 32'(clear_done), 32'(m_done));
            check("overflow_count", 32'(overflow_count), 32'(m_ovf));
            check("oob_count", 32'(oob_count), 32'(m_oob));
            if (fb_valid && fb_ready) begin
                wlog.push_back('{idx: fb_addr, data: fb_data});
            end
            if (clear_done) done_seen = 1;
        end
    end

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit cr, input logic [31:0] cd, input bit rdy);
        video_we = we; video_addr = a; video_data = d;
        clear_req = cr; clear_data = cd; fb_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input bit rdy);
        repeat (cycles) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic check_wr(input string name, input int i, input logic [11:0] idx,
                            input logic [31:0] data);
        wr_t w;
        w = (i < wlog.size()) ? wlog[i] : '1;
        check({name, "_idx"}, 32'(w.idx), 32'(idx));
        check({name, "_data"}, w.data, data);
    endtask

    initial begin
        rst = 1'b1;
        video_we = 0; video_addr = '0; video_data = '0;
        clear_req = 0; clear_data = '0; fb_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_valid", 32'(fb_valid), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 1: two stores, drain with ready high
        wlog.delete();
        step(1, 32'h8000, 32'hAA, 0, 0, 1);
        check("t1_first_valid", 32'(fb_valid), 32'd1);
        check("t1_first_addr", 32'(fb_addr), 32'd0);
        step(1, 32'h8004, 32'hBB, 0, 0, 1);
        idle(3, 1);
        check("t1_nwrites", 32'(wlog.size()), 32'd2);
        check_wr("t1_w0", 0, 12'd0, 32'hAA);
        check_wr("t1_w1", 1, 12'd1, 32'hBB);

        // 2: write-combine to the same word
        wlog.delete();
        step(1, 32'h8010, 32'd1, 0, 0, 0);
        step(1, 32'h8010, 32'd2, 0, 0, 0);
        check("t2_level", 32'(fifo_level), 32'd1);
        idle(3, 1);
        check("t2_nwrites", 32'(wlog.size()), 32'd1);
        check_wr("t2_w0", 0, 12'd4, 32'd2);

        // 3: overflow, then store at full while popping
        wlog.delete();
        for (int i = 0; i < 9; i++) step(1, BASE + 32'(4 * i), 32'h100 + 32'(i), 0, 0, 0);
        check("t3_level_full", 32'(fifo_level), 32'd8);
        check("t3_ovf", 32'(overflow_count), 32'd1);
        step(1, 32'h8100, 32'h200, 0, 0, 1);
        check("t3_ovf_nodrop", 32'(overflow_count), 32'd1);
        check("t3_level_still_full", 32'(fifo_level), 32'd8);
        idle(12, 1);
        check("t3_level_empty", 32'(fifo_level), 32'd0);
        check("t3_nwrites", 32'(wlog.size()), 32'd9);
        check_wr("t3_w0", 0, 12'd0, 32'h100);
        check_wr("t3_w8", 8, 12'd64, 32'h200);

        // 4: illegal addresses
        wlog.delete();
        step(1, 32'h7FFC, 32'h1, 0, 0, 1);
        step(1, 32'h8002, 32'h2, 0, 0, 1);
        step(1, BASE + 32'(FB_WORDS * 4), 32'h3, 0, 0, 1);
        idle(2, 1);
        check("t4_oob", 32'(oob_count), 32'd3);
        check("t4_nwrites", 32'(wlog.size()), 32'd0);

        // 5: clear ordered between old and new stores
        wlog.delete();
        done_seen = 0;
        step(1, 32'h8020, 32'd1, 0, 0, 0);
        step(1, 32'h8024, 32'd2, 0, 0, 0);
        step(1, 32'h8028, 32'd3, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 32'h55, 0);
        check("t5_busy", 32'(busy), 32'd1);
        step(1, 32'h8008, 32'd7, 0, 0, 0);
        for (int k = 0; k < 5000 && !done_seen; k++) idle(1, 1);
        check("t5_done_seen", 32'(done_seen), 32'd1);
        idle(3, 1);
        check("t5_nwrites", 32'(wlog.size()), 32'(3 + FB_WORDS + 1));
        check_wr("t5_w0", 0, 12'd8, 32'd1);
        check_wr("t5_w2", 2, 12'd10, 32'd3);
        check_wr("t5_clr0", 3, 12'd0, 32'h55);
        check_wr("t5_clr_last", 3 + FB_WORDS - 1, 12'(FB_WORDS - 1), 32'h55);
        check_wr("t5_post", 3 + FB_WORDS, 12'd2, 32'd7);

        // 6: reset in the middle of a clear
        step(0, 32'h0, 32'h0, 1, 32'h77, 1);
        step(1, 32'h8040, 32'd9, 0, 0, 1);
        idle(99, 1);
        check("t6_clr_idx", 32'(fb_addr), 32'd100);
        check("t6_level_before", 32'(fifo_level), 32'd1);
        rst = 1'b1;
        idle(1, 1);
        rst = 1'b0;
        check("t6_valid", 32'(fb_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_ovf", 32'(overflow_count), 32'd0);
        check("t6_oob", 32'(oob_count), 32'd0);
        idle(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
